freq_sweep_analyzer: RTL and testbench

//  On-chip frequency-response sweeper: steps the sine_gen period from start to stop, waits for DUT settle,

---
 rtl/freq_sweep_analyzer_pkg.sv | 31 +++
 rtl/freq_sweep_analyzer_if.sv | 40 ++++
 rtl/freq_sweep_analyzer_peak_detector.sv | 42 ++++
 rtl/freq_sweep_analyzer.sv | 169 ++++++++++++++++
 tb/tb_freq_sweep_analyzer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_sweep_analyzer_pkg.sv
// Shared types and width helpers for the frequency sweep analyzer.
// Holds the FSM state enum, default parameters and result-word sizing.
package freq_sweep_analyzer_pkg;

    localparam int DEF_WORD_WIDTH   = 16;
    localparam int DEF_PERIOD_WIDTH = 32;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_DEPTH_LOG2   = 8;
    localparam int DEF_CNT_WIDTH    = 24;
    localparam int DEF_GEN_RST_CYC  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN_RST,
        S_SETTLE,
        S_MEASURE,
        S_STORE,
        S_FINISH
    } sweep_state_t;

    // Per-channel field: {novalid, pk2pk[ww:0]}
    function automatic int ch_field_w(input int ww);
        return ww + 2;
    endfunction

    // Result word: {period, ch[n-1], ..., ch[0]}
    function automatic int result_w(input int pw, input int nch, input int ww);
        return pw + nch * ch_field_w(ww);
    endfunction

endpackage

// File: rtl/freq_sweep_analyzer_if.sv
// Control/status/readback bundle of the sweep analyzer.
// master: sweep controller side (drives start/abort/config/rd_addr); slave: analyzer.
interface freq_sweep_analyzer_if
    import freq_sweep_analyzer_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
);
    localparam int RES_W = result_w(PERIOD_WIDTH, NUM_CH, WORD_WIDTH);

    logic                    start;
    logic                    abort;
    logic [PERIOD_WIDTH-1:0] period_start;
    logic [PERIOD_WIDTH-1:0] period_step;
    logic [PERIOD_WIDTH-1:0] period_stop;
    logic [CNT_WIDTH-1:0]    settle_cycles;
    logic [CNT_WIDTH-1:0]    measure_cycles;
    logic                    busy;
    logic                    done;
    logic                    full;
    logic [DEPTH_LOG2:0]     num_results;
    logic [DEPTH_LOG2-1:0]   rd_addr;
    logic [RES_W-1:0]        rd_data;

    modport master (
        output start, abort, period_start, period_step, period_stop,
        output settle_cycles, measure_cycles, rd_addr,
        input  busy, done, full, num_results, rd_data
    );

    modport slave (
        input  start, abort, period_start, period_step, period_stop,
        input  settle_cycles, measure_cycles, rd_addr,
        output busy, done, full, num_results, rd_data
    );

endinterface

// File: rtl/freq_sweep_analyzer_peak_detector.sv
// Per-channel min/max tracker producing peak-to-peak amplitude.
// Ports: clk, rst (async low), clear, valid, sample -> pk2pk, novalid.
module sweep_peak_detector #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         valid,
    input  logic signed [WORD_WIDTH-1:0] sample,
    output logic [WORD_WIDTH:0]          pk2pk,
    output logic                         novalid
);
    logic signed [WORD_WIDTH-1:0] min_q;
    logic signed [WORD_WIDTH-1:0] max_q;
    logic                         seen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q  <= '0;
            max_q  <= '0;
            seen_q <= 1'b0;
        end else if (clear) begin
            seen_q <= 1'b0;
        end else if (valid) begin
            // First valid sample seeds both trackers
            if (!seen_q || sample < min_q) min_q <= sample;
            if (!seen_q || sample > max_q) max_q <= sample;
            seen_q <= 1'b1;
        end
    end

    // One extra bit so full-scale swings cannot overflow
    always_comb begin
        pk2pk = '0;
        if (seen_q)
            pk2pk = {max_q[WORD_WIDTH-1], max_q}
                  - {min_q[WORD_WIDTH-1], min_q};
        novalid = !seen_q;
    end

endmodule

// File: rtl/freq_sweep_analyzer.sv
// Frequency-response sweeper: steps sine_gen period, settles, measures
// per-channel pk2pk and stores {period, fields} in a result RAM.
// Ports: clk, rst (async low), bus (control/status/readback),
// sample_bus/sample_valid (filter outputs), gen_period/gen_rst (to sine_gen).
module freq_sweep_analyzer
    import freq_sweep_analyzer_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int GEN_RST_CYC  = DEF_GEN_RST_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    freq_sweep_analyzer_if.slave         bus,
    input  logic [NUM_CH*WORD_WIDTH-1:0] sample_bus,
    input  logic [NUM_CH-1:0]            sample_valid,
    output logic [PERIOD_WIDTH-1:0]      gen_period,
    output logic                         gen_rst
);
    localparam int CH_W  = ch_field_w(WORD_WIDTH);
    localparam int RES_W = result_w(PERIOD_WIDTH, NUM_CH, WORD_WIDTH);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  LAST_IDX = (DEPTH_LOG2+1)'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(GEN_RST_CYC - 1);

    sweep_state_t            state;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [CNT_WIDTH-1:0]    settle_q;
    logic [CNT_WIDTH-1:0]    meas_q;
    logic [PERIOD_WIDTH-1:0] step_q;
    logic [PERIOD_WIDTH-1:0] stop_q;
    logic [PERIOD_WIDTH:0]   next_period;
    logic                    last_step;
    logic                    ram_last;
    logic                    do_abort;
    logic                    wr_en;
    logic                    trk_clear;
    logic                    trk_on;
    logic [NUM_CH*CH_W-1:0]  ch_fields;
    logic [RES_W-1:0]        mem [DEPTH];

    // Extra carry bit: an overflowing step ends the sweep instead of wrapping
    assign next_period = {1'b0, gen_period} + {1'b0, step_q};
    assign last_step   = next_period > {1'b0, stop_q};
    assign ram_last    = bus.num_results == LAST_IDX;
    assign do_abort    = bus.abort && state != S_IDLE && state != S_FINISH;
    assign wr_en       = state == S_STORE && !bus.abort;
    assign trk_clear   = state == S_GEN_RST;
    assign trk_on      = state == S_MEASURE;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WORD_WIDTH:0] pk2pk;
        logic                novalid;

        sweep_peak_detector #(.WORD_WIDTH(WORD_WIDTH)) u_pk (
            .clk     (clk),
            .rst     (rst),
            .clear   (trk_clear),
            .valid   (sample_valid[k] & trk_on),
            .sample  (sample_bus[k*WORD_WIDTH +: WORD_WIDTH]),
            .pk2pk   (pk2pk),
            .novalid (novalid)
        );

        assign ch_fields[k*CH_W +: CH_W] = {novalid, pk2pk};
    end

    // Simple dual-port RAM; read-during-write returns old data
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[bus.num_results[DEPTH_LOG2-1:0]] <= {gen_period, ch_fields};
        bus.rd_data <= mem[bus.rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            settle_q        <= '0;
            meas_q          <= '0;
            step_q          <= '0;
            stop_q          <= '0;
            gen_period      <= '0;
            gen_rst         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.full        <= 1'b0;
            bus.num_results <= '0;
        end else begin
            bus.done <= 1'b0;
            if (do_abort) begin
                state    <= S_FINISH;
                bus.done <= 1'b1;
                gen_rst  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            step_q   <= (bus.period_step == '0)
                                      ? PERIOD_WIDTH'(1) : bus.period_step;
                            meas_q   <= (bus.measure_cycles == '0)
                                      ? CNT_WIDTH'(1) : bus.measure_cycles;
                            stop_q          <= bus.period_stop;
                            settle_q        <= bus.settle_cycles;
                            gen_period      <= bus.period_start;
                            bus.num_results <= '0;
                            bus.full        <= 1'b0;
                            bus.busy        <= 1'b1;
                            gen_rst         <= 1'b0;
                            cnt             <= '0;
                            state           <= S_GEN_RST;
                        end
                    end
                    S_GEN_RST: begin
                        if (cnt == RST_LAST) begin
                            cnt     <= '0;
                            gen_rst <= 1'b1;
                            state   <= (settle_q == '0) ? S_MEASURE : S_SETTLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == settle_q - 1'b1) begin
                            cnt   <= '0;
                            state <= S_MEASURE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        if (cnt == meas_q - 1'b1) begin
                            cnt   <= '0;
                            state <= S_STORE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STORE: begin
                        bus.num_results <= bus.num_results + 1'b1;
                        if (last_step) begin
                            state    <= S_FINISH;
                            bus.done <= 1'b1;
                            gen_rst  <= 1'b0;
                        end else if (ram_last) begin
                            bus.full <= 1'b1;
                            state    <= S_FINISH;
                            bus.done <= 1'b1;
                            gen_rst  <= 1'b0;
                        end else begin
                            gen_period <= next_period[PERIOD_WIDTH-1:0];
                            gen_rst    <= 1'b0;
                            state      <= S_GEN_RST;
                        end
                    end
                    S_FINISH: begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_sweep_analyzer.sv
// Randomized directed bench for freq_sweep_analyzer.
// Reference model: period list and per-window min/max from sweep rules.
module tb_freq_sweep_analyzer;
    import freq_sweep_analyzer_pkg::*;

    localparam int W     = 16;
    localparam int PW    = 32;
    localparam int NCH   = 4;
    localparam int DL    = 8;
    localparam int CW    = 24;
    localparam int DEPTH = 1 << DL;
    localparam int CHW   = W + 2;
    localparam int RESW  = PW + NCH * CHW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH*W-1:0]   sample_bus;
    logic [NCH-1:0]     sample_valid;
    logic [PW-1:0]      gen_period;
    logic               gen_rst;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int mode = 0;
    bit alt = 1'b0;

    longint exp_period[$];
    int     exp_pk [DEPTH][NCH];
    bit     exp_nv [DEPTH][NCH];
    bit     exp_full;
    int     mn [NCH];
    int     mx [NCH];
    bit     seen [NCH];

    always #2 clk = ~clk;

    freq_sweep_analyzer_if #(
        .WORD_WIDTH(W), .PERIOD_WIDTH(PW), .NUM_CH(NCH),
        .DEPTH_LOG2(DL), .CNT_WIDTH(CW)
    ) bus ();

    freq_sweep_analyzer #(
        .WORD_WIDTH(W), .PERIOD_WIDTH(PW), .NUM_CH(NCH),
        .DEPTH_LOG2(DL), .CNT_WIDTH(CW), .GEN_RST_CYC(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sample_bus   (sample_bus),
        .sample_valid (sample_valid),
        .gen_period   (gen_period),
        .gen_rst      (gen_rst)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic signed [W-1:0] v;
        for (int k = 0; k < NCH; k++) begin
            v = W'($urandom);
            if (mode == 0) begin
                unique case (k)
                    0: begin v = 16'sh0100; sample_valid[k] = 1'b1; end
                    1: begin
                        v = alt ? 16'sd1000 : -16'sd1000;
                        sample_valid[k] = 1'b1;
                    end
                    2: sample_valid[k] = 1'b0;
                    default: sample_valid[k] = 1'($urandom_range(0, 1));
                endcase
            end else begin
                sample_valid[k] = ($urandom_range(0, 3) == 0);
            end
            sample_bus[k*W +: W] = v;
        end
        alt = ~alt;
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.done === 1'b1) done_cnt++;
        drive();
    endtask

    task automatic accumulate();
        int v;
        for (int k = 0; k < NCH; k++) begin
            if (sample_valid[k]) begin
                v = int'($signed(sample_bus[k*W +: W]));
                if (!seen[k] || v < mn[k]) mn[k] = v;
                if (!seen[k] || v > mx[k]) mx[k] = v;
                seen[k] = 1'b1;
            end
        end
    endtask

    task automatic wait_gen_rst(input logic val, input int limit,
                                output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (gen_rst === val) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_start(input longint ps, input longint step,
                               input longint stop, input longint settle,
                               input longint meas);
        bus.period_start   = ps[PW-1:0];
        bus.period_step    = step[PW-1:0];
        bus.period_stop    = stop[PW-1:0];
        bus.settle_cycles  = settle[CW-1:0];
        bus.measure_cycles = meas[CW-1:0];
        done_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_sweep(input longint ps, input longint step,
                             input longint stop, input longint settle,
                             input longint meas, input int md);
        longint step_e, meas_e, p;
        bit ok;
        logic [RESW-1:0] rd;
        logic [CHW-1:0] ef;
        string tag;
        step_e = (step == 0) ? 1 : step;
        meas_e = (meas == 0) ? 1 : meas;
        exp_period.delete();
        exp_full = 1'b0;
        p = ps;
        forever begin
            exp_period.push_back(p);
            if (p + step_e > stop) break;
            if (exp_period.size() == DEPTH) begin
                exp_full = 1'b1;
                break;
            end
            p = p + step_e;
        end
        mode = md;
        pulse_start(ps, step, stop, settle, meas);
        for (int e = 0; e < exp_period.size(); e++) begin
            wait_gen_rst(1'b1, 64, ok);
            if (!ok) begin
                check("gen_rst_rise_timeout", 64'(ok), 64'd1);
                return;
            end
            for (int k = 0; k < NCH; k++) seen[k] = 1'b0;
            for (longint j = 0; j < settle + meas_e; j++) begin
                if (j >= settle) accumulate();
                tick();
            end
            for (int k = 0; k < NCH; k++) begin
                exp_nv[e][k] = !seen[k];
                exp_pk[e][k] = seen[k] ? mx[k] - mn[k] : 0;
            end
            wait_gen_rst(1'b0, 8, ok);
            if (!ok) begin
                check("gen_rst_fall_timeout", 64'(ok), 64'd1);
                return;
            end
        end
        for (int i = 0; i < 8 && bus.busy !== 1'b0; i++) tick();
        check("end_busy", 64'(bus.busy), 64'd0);
        check("end_gen_rst", 64'(gen_rst), 64'd0);
        check("num_results", 64'(bus.num_results), 64'(exp_period.size()));
        check("full", 64'(bus.full), 64'(exp_full));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("last_period", 64'(gen_period),
              64'(exp_period[exp_period.size()-1]));
        for (int e = 0; e < exp_period.size(); e++) begin
            bus.rd_addr = DL'(e);
            tick();
            rd = bus.rd_data;
            tag = $sformatf("entry%0d_period", e);
            check(tag, 64'(rd[RESW-1 -: PW]), 64'(exp_period[e]));
            for (int k = 0; k < NCH; k++) begin
                ef = {exp_nv[e][k], 17'(exp_pk[e][k])};
                tag = $sformatf("entry%0d_ch%0d", e, k);
                check(tag, 64'(rd[k*CHW +: CHW]), 64'(ef));
            end
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.period_start = '0;
        bus.period_step = '0;
        bus.period_stop = '0;
        bus.settle_cycles = '0;
        bus.measure_cycles = '0;
        bus.rd_addr = '0;
        drive();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_num", 64'(bus.num_results), 64'd0);
        check("rst_gen_rst", 64'(gen_rst), 64'd0);
        check("rst_gen_period", 64'(gen_period), 64'd0);
        rst = 1'b1;
        tick();

        run_sweep(2, 5, 22, 100, 64, 0);
        run_sweep(5, 3, 30, 7, 9, 1);
        run_sweep(7, 0, 9, 0, 0, 1);
        run_sweep(50, 4, 10, 2, 6, 0);
        run_sweep(1, 1, 1000, 0, 2, 0);
        run_sweep(64'hFFFF_FFF0, 64'h20, 64'hFFFF_FFFF, 3, 5, 1);
        run_sweep(64'hFFFF_FFF0, 64'hF, 64'hFFFF_FFFF, 1, 3, 0);

        // Abort (with a simultaneous start) during MEASURE of step 3
        mode = 0;
        pulse_start(2, 5, 100, 5, 50);
        for (int s = 0; s < 3; s++) begin
            wait_gen_rst(1'b1, 64, ok);
            check("abort_rise", 64'(ok), 64'd1);
            if (s < 2) begin
                wait_gen_rst(1'b0, 200, ok);
                check("abort_fall", 64'(ok), 64'd1);
            end
        end
        repeat (15) tick();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_done", 64'(bus.done), 64'd1);
        check("abort_gen_rst", 64'(gen_rst), 64'd0);
        tick();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_num", 64'(bus.num_results), 64'd2);
        check("abort_period", 64'(gen_period), 64'd12);
        check("abort_done_cnt", 64'(done_cnt), 64'd1);
        repeat (4) tick();
        check("abort_stays_idle", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a sweep
        pulse_start(3, 1, 50, 2, 4);
        repeat (60) tick();
        check("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_full", 64'(bus.full), 64'd0);
        check("mid_rst_num", 64'(bus.num_results), 64'd0);
        check("mid_rst_gen_rst", 64'(gen_rst), 64'd0);
        check("mid_rst_period", 64'(gen_period), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        run_sweep(4, 2, 8, 1, 3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
